// File: rtl/sqrt_nr_iter.sv
// sqrt_nr_iter: iterative non-restoring integer square root.
// Takes a 2*WIDTH-bit unsigned radicand and resolves STEPS_PER_CYCLE root bits
// per clock, then applies one fix-up cycle to produce the exact remainder.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - radicand valid
//   in_ready   - unit idle and able to accept a radicand
//   radicand   - 2*WIDTH-bit unsigned operand
//   out_valid  - dout/remainder valid (held until out_ready)
//   out_ready  - consumer accepts the result
//   dout       - floor(sqrt(radicand))
//   remainder  - radicand - dout*dout, range 0..2*dout
module sqrt_nr_iter #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned STEPS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] radicand,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dout,
    output logic [WIDTH:0]     remainder
);

    localparam int unsigned ITERS = WIDTH / STEPS_PER_CYCLE;
    // Sized so a single-iteration configuration still gets a 1-bit counter.
    localparam int unsigned CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] op;     // radicand, shifted left as bit pairs are consumed
    logic [WIDTH-1:0]   q;
    logic [WIDTH+1:0]   r;      // two's complement partial remainder

    logic [2*WIDTH-1:0] op_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic [WIDTH+1:0]   r_nxt;
    logic [1:0]         pair;
    logic [WIDTH:0]     r_fix;

    // STEPS_PER_CYCLE chained non-restoring steps.
    always_comb begin
        op_nxt = op;
        q_nxt  = q;
        r_nxt  = r;
        pair   = 2'b00;
        for (int unsigned k = 0; k < STEPS_PER_CYCLE; k++) begin
            pair   = op_nxt[2*WIDTH-1 -: 2];
            op_nxt = op_nxt << 2;
            if (!r_nxt[WIDTH+1]) begin
                r_nxt = {r_nxt[WIDTH-1:0], pair} - {q_nxt, 2'b01};
            end else begin
                r_nxt = {r_nxt[WIDTH-1:0], pair} + {q_nxt, 2'b11};
            end
            q_nxt = {q_nxt[WIDTH-2:0], ~r_nxt[WIDTH+1]};
        end
    end

    // Final correction; the corrected value lies in 0..2Q, so WIDTH+1 bits of
    // modular arithmetic are exact.
    assign r_fix = r[WIDTH+1] ? (r[WIDTH:0] + {q, 1'b1}) : r[WIDTH:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            q         <= '0;
            r         <= '0;
            dout      <= '0;
            remainder <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op    <= radicand;
                        q     <= '0;
                        r     <= '0;
                        cnt   <= CNT_LOAD;
                        state <= CALC;
                    end
                end
                CALC: begin
                    op <= op_nxt;
                    q  <= q_nxt;
                    r  <= r_nxt;
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    dout      <= q;
                    remainder <= r_fix;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_sqrt_nr_iter.sv
// tb_sqrt_nr_iter: self-checking bench for sqrt_nr_iter.
// Instance A is WIDTH=4/SPC=1, instance B is WIDTH=8/SPC=2. Expected results
// come from a plain floor-sqrt reference; inputs are driven and outputs
// sampled on the falling clock edge.
module tb_sqrt_nr_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        sel;          // 0 drives instance A, 1 drives instance B
    logic [15:0] rad;

    logic       a_in_ready, a_out_valid;
    logic [3:0] a_dout;
    logic [4:0] a_rem;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_dout;
    logic [8:0] b_rem;

    logic       obs_in_ready, obs_out_valid;
    logic [7:0] obs_dout;
    logic [8:0] obs_rem;

    int checks   = 0;
    int failures = 0;

    sqrt_nr_iter #(.WIDTH(4), .STEPS_PER_CYCLE(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid && !sel),
        .in_ready  (a_in_ready),
        .radicand  (rad[7:0]),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .dout      (a_dout),
        .remainder (a_rem)
    );

    sqrt_nr_iter #(.WIDTH(8), .STEPS_PER_CYCLE(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid && sel),
        .in_ready  (b_in_ready),
        .radicand  (rad),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .dout      (b_dout),
        .remainder (b_rem)
    );

    assign obs_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign obs_out_valid = sel ? b_out_valid : a_out_valid;
    assign obs_dout      = sel ? b_dout      : {4'b0000, a_dout};
    assign obs_rem       = sel ? b_rem       : {4'b0000, a_rem};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned isqrt(input int unsigned x);
        int unsigned s;
        s = 0;
        while ((s + 1) * (s + 1) <= x) s++;
        return s;
    endfunction

    // One full transaction on the selected instance, starting at a falling edge.
    task automatic run_op(input bit use_b, input int unsigned x, input bit rand_bp,
                          input bit hold_valid);
        int unsigned s, lat, n;
        logic [7:0]  hd;
        logic [8:0]  hr;
        s         = isqrt(x);
        sel       = use_b;
        rad       = 16'(x);
        in_valid  = 1'b1;
        out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        n = 0;
        while (!obs_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(obs_in_ready), 32'd1);
        @(negedge clk);                       // acceptance edge has passed
        if (!hold_valid) in_valid = 1'b0;
        lat = 0;
        while (!obs_out_valid && lat < 40) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            check("busy_in_ready", 32'(obs_in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 32'd5);
        check("dout", 32'(obs_dout), s);
        check("remainder", 32'(obs_rem), x - s * s);
        check("done_in_ready", 32'(obs_in_ready), 32'd0);
        in_valid = 1'b0;
        hd = obs_dout;
        hr = obs_rem;
        n = 0;
        while (!out_ready && n < 30) begin
            @(negedge clk);
            n++;
            check("bp_valid", 32'(obs_out_valid), 32'd1);
            check("bp_dout", 32'(obs_dout), 32'(hd));
            check("bp_rem", 32'(obs_rem), 32'(hr));
            out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        @(negedge clk);                       // handshake edge has passed
        check("post_valid", 32'(obs_out_valid), 32'd0);
        check("post_in_ready", 32'(obs_in_ready), 32'd1);
        check("post_dout_kept", 32'(obs_dout), s);
        if (hold_valid) begin
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check("no_reaccept", 32'(obs_out_valid), 32'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned dir_a [4] = '{0, 15, 16, 255};
        int unsigned dir_b [3] = '{65535, 65025, 1000};

        // Reset held with in_valid asserted.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sel       = 1'b0;
        rad       = 16'd200;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_a_dout", 32'(a_dout), 32'd0);
        check("rst_a_rem", 32'(a_rem), 32'd0);
        check("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        check("rst_b_dout", 32'(b_dout), 32'd0);
        check("rst_b_rem", 32'(b_rem), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_spurious", 32'(a_out_valid | b_out_valid), 32'd0);
        end

        // Directed values, out_ready tied high.
        foreach (dir_a[i]) run_op(1'b0, dir_a[i], 1'b0, 1'b0);
        foreach (dir_b[i]) run_op(1'b1, dir_b[i], 1'b0, 1'b0);

        // Reset two cycles into CALC aborts the operand.
        sel       = 1'b0;
        rad       = 16'd200;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("aborted_no_valid", 32'(a_out_valid), 32'd0);
        end
        run_op(1'b0, 144, 1'b0, 1'b0);

        // in_valid held through CALC must not be re-accepted.
        run_op(1'b0, 99, 1'b0, 1'b1);
        run_op(1'b1, 12345, 1'b1, 1'b1);

        // Exhaustive WIDTH=4 sweep with random backpressure.
        for (int unsigned v = 0; v < 256; v++) run_op(1'b0, v, 1'b1, 1'b0);

        // Random WIDTH=8 operands with random backpressure.
        for (int i = 0; i < 24; i++) run_op(1'b1, $urandom_range(0, 65535), 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sqrt_nr_iter.md
# sqrt_nr_iter

Iterative non-restoring integer square-root unit with valid/ready handshakes on input and output. It replaces the fully unrolled square-root cell chain where area matters more than throughput. It takes a 2*WIDTH-bit radicand and resolves STEPS_PER_CYCLE root bits per clock. It returns both the root and the exact remainder. It sits between a streaming producer and consumer in the arithmetic datapath and accepts one operand at a time.

## Interface
- WIDTH, 4: root width; radicand is 2*WIDTH bits; WIDTH >= 2.
- STEPS_PER_CYCLE, 1: root bits resolved per clock; must divide WIDTH exactly (1, 2 or WIDTH).
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  radicand valid.
- in_ready  output  1  unit can accept a radicand (high only in IDLE).
- radicand  input  2*WIDTH  unsigned operand; sampled on in_valid && in_ready.
- out_valid  output  1  root/remainder valid.
- out_ready  input  1  consumer accepts the result.
- dout  output  WIDTH  floor(sqrt(radicand)).
- remainder  output  WIDTH+1  radicand - dout*dout; range 0..2*dout.

## Operation
- States and transitions:
  - IDLE -> CALC on in_valid && in_ready.
  - CALC -> FIX after WIDTH/STEPS_PER_CYCLE cycles.
  - FIX -> DONE after 1 cycle.
  - DONE -> IDLE on out_valid && out_ready.
- Accept: latch radicand into an operand register, clear Q (WIDTH bits) and R (signed, WIDTH+2 bits), and load the iteration counter with WIDTH/STEPS_PER_CYCLE - 1.
- Each CALC cycle runs STEPS_PER_CYCLE chained combinational steps. Step k consumes the next radicand bit pair D[2i+1:2i], starting with i = WIDTH-1:
  - If R >= 0: R <- (R<<2 | pair) - (Q<<2 | 1).
  - Else: R <- (R<<2 | pair) + (Q<<2 | 3).
  - Then Q <- Q<<1 | (R >= 0).
- CALC ends when the counter reaches 0. The counter decrements by 1 per cycle.
- FIX: if R < 0, R <- R + (Q<<1 | 1); otherwise R is unchanged. Register dout = Q and remainder = R[WIDTH:0].
- DONE: out_valid = 1. dout and remainder hold stable until the handshake completes.
- All arithmetic is in WIDTH+2-bit two's complement. No intermediate value overflows for any radicand in 0..2^(2*WIDTH)-1.
- Operand register, Q and R are don't-care outside CALC/FIX. dout and remainder keep their last result after returning to IDLE.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - State goes to IDLE; counter = 0; Q, R, dout and remainder = 0.
  - out_valid = 0; in_ready = 1 from the first cycle after reset release.
- Reset mid-operation (CALC, FIX or DONE) aborts the operand. No out_valid is produced for it.
- Latency: an operand accepted at edge n gives out_valid = 1 after edge n + WIDTH/STEPS_PER_CYCLE + 1.
  - WIDTH=4, SPC=1: 5 cycles.
  - WIDTH=8, SPC=2: 5 cycles.
  - WIDTH=8, SPC=1: 9 cycles.
- Throughput: at most one operand per WIDTH/STEPS_PER_CYCLE + 3 cycles (accept, CALC, FIX, DONE handshake, IDLE).
- in_ready is a registered-state decode: in_ready = (state == IDLE). It does not depend combinationally on out_ready.
- The cycle that completes the output handshake does not also accept a new radicand.
- Backpressure: out_valid stays high and outputs stay frozen for any number of cycles with out_ready = 0.
- out_ready asserted before out_valid has no effect.
- in_valid while in_ready = 0 is ignored. The producer must hold in_valid and radicand until accepted.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 -> in_ready = 1, out_valid = 0, dout = 0, remainder = 0 after release. No spurious result appears.
- WIDTH=4, SPC=1, out_ready tied high. Radicands 0, 15, 16, 255 -> outputs:
  - 0 -> (0, 0)
  - 15 -> (3, 6)
  - 16 -> (4, 0)
  - 255 -> (15, 30)
  - Each has out_valid exactly 5 cycles after acceptance.
- Exhaustive WIDTH=4, SPC=1 sweep of 0..255 with random out_ready backpressure -> every result matches the floor-sqrt/remainder model. Outputs stay stable while out_valid && !out_ready.
- WIDTH=8, SPC=2: radicands 65535, 65025, 1000 -> outputs:
  - 65535 -> (255, 510)
  - 65025 -> (255, 0)
  - 1000 -> (31, 39)
  - Latency is 5 cycles.
- Reset mid-CALC: accept 200, assert rst_n = 0 two cycles later -> out_valid never rises for 200. The next accepted 144 returns (12, 0) with normal latency.
- Handshake corners:
  - in_valid held during CALC is not re-accepted.
  - With out_ready high on the DONE cycle, in_ready is low in that cycle and high in the next.
